// File: rtl/ysyx_25030081_alu_arb.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between NREQ requesters.
// Optional opcode legality check: define YSYX_25030081_ALU_ARB_OPCHK_EN.
module ysyx_25030081_alu_arb #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*4-1:0]          req_op,
  input  logic [NREQ*DATA_WIDTH-1:0] req_op1,
  input  logic [NREQ*DATA_WIDTH-1:0] req_op2,
  input  logic [NREQ*TAG_W-1:0]      req_tag,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_out,
  output logic                       rsp_zero,
  output logic                       rsp_less,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_err,
  output logic [3:0]                 alu_op,
  output logic [DATA_WIDTH-1:0]      alu_op1,
  output logic [DATA_WIDTH-1:0]      alu_op2,
  input  logic [DATA_WIDTH-1:0]      alu_out,
  input  logic                       alu_zero,
  input  logic                       alu_less
);
  localparam int IDW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        last_grant_q, last_grant_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  zero_q, zero_d, less_q, less_d, rerr_q, rerr_d;

  logic [IDW-1:0]        gnt_id, idx;
  logic                  gnt_found, op_ok;
  logic [3:0]            sel_op;

  // Search upward from last_grant+1 so the most recently served requester is last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_grant_q) + k) % NREQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  assign sel_op = req_op[4*gnt_id +: 4];

`ifdef YSYX_25030081_ALU_ARB_OPCHK_EN
  always_comb begin
    case (sel_op)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b1010, 4'b0011,
      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: op_ok = 1'b1;
      default:                                      op_ok = 1'b0;
    endcase
  end
`else
  assign op_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    tag_d        = tag_q;
    err_d        = err_q;
    out_d        = out_q;
    zero_d       = zero_q;
    less_d       = less_q;
    rerr_d       = rerr_q;
    req_ready    = '0;
    rsp_valid    = '0;
    unique case (state_q)
      IDLE: if (gnt_found) begin
        req_ready[gnt_id] = 1'b1;
        id_d    = gnt_id;
        tag_d   = req_tag[TAG_W*gnt_id +: TAG_W];
        // Illegal ops run as 0+0 so the ALU sees a harmless, deterministic input.
        op_d    = op_ok ? sel_op : 4'b0000;
        op1_d   = op_ok ? req_op1[DATA_WIDTH*gnt_id +: DATA_WIDTH] : '0;
        op2_d   = op_ok ? req_op2[DATA_WIDTH*gnt_id +: DATA_WIDTH] : '0;
        err_d   = ~op_ok;
        state_d = EXEC;
      end
      EXEC: begin
        out_d   = err_q ? '0 : alu_out;
        zero_d  = err_q | alu_zero;
        less_d  = ~err_q & alu_less;
        rerr_d  = err_q;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        if (rsp_ready[id_q]) begin
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ-1);
      id_q         <= '0;
      op_q         <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      tag_q        <= '0;
      err_q        <= 1'b0;
      out_q        <= '0;
      zero_q       <= 1'b0;
      less_q       <= 1'b0;
      rerr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
      out_q        <= out_d;
      zero_q       <= zero_d;
      less_q       <= less_d;
      rerr_q       <= rerr_d;
    end
  end

  assign alu_op   = op_q;
  assign alu_op1  = op1_q;
  assign alu_op2  = op2_q;
  assign rsp_out  = out_q;
  assign rsp_zero = zero_q;
  assign rsp_less = less_q;
  assign rsp_tag  = tag_q;
  assign rsp_err  = rerr_q;

endmodule

// File: tb/tb_ysyx_25030081_alu_arb.sv
// Directed bench for ysyx_25030081_alu_arb with a small add/sub ALU model attached.
module tb_ysyx_25030081_alu_arb;
  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int TW   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ*DW-1:0] req_op1, req_op2;
  logic [NREQ*TW-1:0] req_tag;
  logic [DW-1:0]     rsp_out, alu_op1, alu_op2, alu_out;
  logic              rsp_zero, rsp_less, rsp_err, alu_zero, alu_less;
  logic [TW-1:0]     rsp_tag;
  logic [3:0]        alu_op;

  int checks   = 0;
  int failures = 0;

  ysyx_25030081_alu_arb #(.NREQ(NREQ), .DATA_WIDTH(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_zero(rsp_zero), .rsp_less(rsp_less), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_less(alu_less)
  );

  // External ALU stand-in: 1000 subtracts, everything else adds.
  assign alu_out  = (alu_op == 4'b1000) ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
  assign alu_zero = (alu_out == '0);
  assign alu_less = ($signed(alu_op1) < $signed(alu_op2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_op = '0; req_op1 = '0; req_op2 = '0; req_tag = '0;
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_out",   64'(rsp_out),   64'd0);
    check("rst_rsp_flags", {61'd0, rsp_zero, rsp_less, rsp_err}, 64'd0);
    check("rst_rsp_tag",   64'(rsp_tag),   64'd0);
    check("rst_alu_op",    64'(alu_op),    64'd0);
    check("rst_alu_op1",   64'(alu_op1),   64'd0);
    check("rst_alu_op2",   64'(alu_op2),   64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Single add on requester 0
    step();
    req_valid = 2'b01; req_op[3:0] = 4'b0000; req_op1[31:0] = 32'd5;
    req_op2[31:0] = 32'd7; req_tag[3:0] = 4'd3;
    #1 check("add_req_ready", 64'(req_ready), 64'h1);
    step(); req_valid = '0;
    check("add_exec_ready", 64'(req_ready), 64'd0);
    check("add_alu_op1",    64'(alu_op1),   64'd5);
    check("add_alu_op2",    64'(alu_op2),   64'd7);
    check("add_exec_valid", 64'(rsp_valid), 64'd0);
    step();
    check("add_rsp_valid", 64'(rsp_valid), 64'h1);
    check("add_rsp_out",   64'(rsp_out),   64'd12);
    check("add_rsp_zero",  64'(rsp_zero),  64'd0);
    check("add_rsp_tag",   64'(rsp_tag),   64'd3);
    rsp_ready = 2'b01;
    step(); rsp_ready = '0;
    check("add_done_valid", 64'(rsp_valid), 64'd0);

    // Subtract on requester 1, then backpressure with requester 0 waiting
    req_valid = 2'b10; req_op[7:4] = 4'b1000; req_op1[63:32] = 32'd3;
    req_op2[63:32] = 32'd5; req_tag[7:4] = 4'd5;
    #1 check("sub_req_ready", 64'(req_ready), 64'h2);
    step(); req_valid = '0;
    step();
    check("sub_rsp_valid", 64'(rsp_valid), 64'h2);
    check("sub_rsp_out",   64'(rsp_out),   64'hFFFF_FFFE);
    check("sub_rsp_less",  64'(rsp_less),  64'd1);
    check("sub_rsp_zero",  64'(rsp_zero),  64'd0);
    check("sub_rsp_tag",   64'(rsp_tag),   64'd5);
    req_valid = 2'b01; req_op[3:0] = 4'b0000; req_op1[31:0] = 32'd1;
    req_op2[31:0] = 32'd1; req_tag[3:0] = 4'd7;
    rsp_ready = 2'b01;  // wrong requester's ready must be ignored
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_rsp_valid", 64'(rsp_valid), 64'h2);
      check("bp_rsp_out",   64'(rsp_out),   64'hFFFF_FFFE);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 2'b10;
    step(); rsp_ready = '0;
    check("bp_rel_valid", 64'(rsp_valid), 64'd0);
    check("bp_rel_grant", 64'(req_ready), 64'h1);
    step(); req_valid = '0;
    step();
    check("bp_next_valid", 64'(rsp_valid), 64'h1);
    check("bp_next_out",   64'(rsp_out),   64'd2);
    check("bp_next_tag",   64'(rsp_tag),   64'd7);
    rsp_ready = 2'b01;
    step(); rsp_ready = '0;

    // Reset during EXEC
    req_valid = 2'b10; req_op[7:4] = 4'b0000; req_op1[63:32] = 32'd1;
    req_op2[63:32] = 32'd2; req_tag[7:4] = 4'd9;
    #1 check("rmo_grant", 64'(req_ready), 64'h2);
    step(); req_valid = '0;
    check("rmo_exec_op1", 64'(alu_op1), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rmo_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rmo_alu_op1",   64'(alu_op1),   64'd0);
    check("rmo_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("rmo_no_rsp", 64'(rsp_valid), 64'd0);

    // Contention: grants rotate 0,1,0,1 starting at 0
    req_op = {4'b0000, 4'b0000};
    req_op1 = {32'd100, 32'd10}; req_op2 = {32'd1, 32'd20};
    req_tag = {4'd2, 4'd1};
    rsp_ready = 2'b11; req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_grant", 64'(req_ready), (i % 2) ? 64'h2 : 64'h1);
      step();
      check("rr_exec_ready", 64'(req_ready), 64'd0);
      step();
      check("rr_rsp_valid", 64'(rsp_valid), (i % 2) ? 64'h2 : 64'h1);
      check("rr_rsp_tag",   64'(rsp_tag),   (i % 2) ? 64'd2 : 64'd1);
      check("rr_rsp_out",   64'(rsp_out),   (i % 2) ? 64'd101 : 64'd30);
      step();
    end

    // Illegal opcode
    req_valid = 2'b01; rsp_ready = '0; req_op[3:0] = 4'b1111;
    req_op1[31:0] = 32'd1; req_op2[31:0] = 32'd1; req_tag[3:0] = 4'd4;
    #1 check("chk_grant", 64'(req_ready), 64'h1);
    step(); req_valid = '0;
    step();
    check("chk_rsp_valid", 64'(rsp_valid), 64'h1);
    check("chk_rsp_tag",   64'(rsp_tag),   64'd4);
`ifdef YSYX_25030081_ALU_ARB_OPCHK_EN
    check("chk_alu_op",   64'(alu_op),   64'd0);
    check("chk_rsp_err",  64'(rsp_err),  64'd1);
    check("chk_rsp_out",  64'(rsp_out),  64'd0);
    check("chk_rsp_zero", 64'(rsp_zero), 64'd1);
`else
    check("chk_alu_op",   64'(alu_op),   64'hF);
    check("chk_rsp_err",  64'(rsp_err),  64'd0);
    check("chk_rsp_out",  64'(rsp_out),  64'd2);
    check("chk_rsp_zero", 64'(rsp_zero), 64'd0);
`endif
    check("chk_rsp_less", 64'(rsp_less), 64'd0);
    rsp_ready = 2'b01;
    step(); rsp_ready = '0;
    check("chk_done_valid", 64'(rsp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_25030081_alu_arb.md
# ysyx_25030081_alu_arb

- Round-robin arbiter and sequencer that shares one combinational ALU between `NREQ` requesters (e.g. EXU and a multi-cycle helper unit).
- Accepts one request at a time and drives the external ALU from registered operands.
- Captures the ALU result and returns it to the granted requester over a valid/ready response channel, tagged with requester id and user tag.

## Interface
Parameters:
- `NREQ`, 2, number of requesters, legal range 2..4
- `DATA_WIDTH`, 32, operand/result width
- `TAG_W`, 4, per-request user tag width

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  request valid, one bit per requester
- `req_ready`  out  NREQ  request accepted this cycle (one-hot or zero)
- `req_op`  in  NREQ*4  ALU opcode, requester i at [4i+3:4i]
- `req_op1`, `req_op2`  in  NREQ*DATA_WIDTH  operands, requester i at slice i
- `req_tag`  in  NREQ*TAG_W  user tag, slice i
- `rsp_valid`  out  NREQ  response valid for requester i (one-hot or zero)
- `rsp_ready`  in  NREQ  requester i consumes response
- `rsp_out`  out  DATA_WIDTH  captured ALU result
- `rsp_zero`, `rsp_less`  out  1  captured ALU flags
- `rsp_tag`  out  TAG_W  tag of the request being answered
- `rsp_err`  out  1  illegal opcode flag (see Configuration)
- `alu_op`  out  4  to ALU; `alu_op1`, `alu_op2`  out  DATA_WIDTH  to ALU
- `alu_out`  in  DATA_WIDTH; `alu_zero`, `alu_less`  in  1  from ALU (combinational)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid`, grant the first set bit searching upward from `last_grant+1` (mod NREQ).
  - Assert that requester's `req_ready` combinationally in the same cycle.
  - Latch op/op1/op2/tag/id into the issue registers; go to EXEC.
  - With no `req_valid`, stay in IDLE with all `req_ready`=0.
- EXEC:
  - `alu_*` outputs are driven from the issue registers; the ALU settles within the cycle.
  - Capture `alu_out`, `alu_zero`, `alu_less` into the response registers; go to RESP.
- RESP:
  - `rsp_valid[id]`=1; response data held stable.
  - On `rsp_ready[id]`=1: `last_grant`<=id, go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `req_ready` is 0 outside IDLE.
- `alu_*` outputs always reflect the issue registers (stable outside EXEC too).
- Protocol: a requester holds `req_valid` and its payload until `req_ready`; the arbiter samples only in IDLE.
- ALU opcode semantics are owned by the ALU; this block passes them through unmodified (except under Configuration).

## Timing
- Reset (async assert, sync release) forces:
  - state IDLE, `last_grant`=NREQ-1 (requester 0 has first priority);
  - `req_ready`=0, `rsp_valid`=0;
  - `rsp_out`=0, `rsp_zero`=0, `rsp_less`=0, `rsp_tag`=0, `rsp_err`=0;
  - `alu_op`=0, `alu_op1`=0, `alu_op2`=0.
- Latency: accept at cycle T (IDLE), ALU evaluates at T+1 (EXEC), `rsp_valid` high from T+2.
- Zero-stall throughput: one operation per 3 cycles.
- Next grant occurs at the earliest in the cycle after the response handshake; there is no accept in the RESP-handshake cycle.
- Simultaneous requests: strict round-robin; with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.
- Backpressure: `rsp_ready`=0 holds RESP indefinitely with outputs unchanged; no new request is accepted.
- Reset mid-operation: the in-flight op is discarded and no response is issued; after release, behaviour is identical to power-up.

## Configuration
- Macro `YSYX_25030081_ALU_ARB_OPCHK_EN`.
- Defined:
  - In IDLE, the accepted opcode is checked against the legal set {0000,1000,0001,0010,1010,0011,0100,0101,1101,0110,0111}.
  - Illegal opcode: issue register op forced to 0000, operands forced to 0.
  - The response then carries `rsp_err`=1, `rsp_out`=0, `rsp_zero`=1, `rsp_less`=0; latency and handshake are unchanged.
- Undefined: no check, opcode passed through as given, `rsp_err` tied 0.

## Test plan
- Single add: req0 op=0000, op1=5, op2=7 -> `req_ready[0]` same cycle; 2 cycles later `rsp_valid[0]`=1, `rsp_out`=12, `rsp_zero`=0, tag echoed.
- Subtract/less: req1 op=1000, op1=3, op2=5 -> `rsp_out`=0xFFFFFFFE, `rsp_less`=1, only `rsp_valid[1]` set.
- Contention: req0 and req1 valid continuously with tags 1 and 2 -> grants alternate 0,1,0,1 starting with 0 after reset; responses appear in that order.
- Backpressure: hold `rsp_ready`=0 for 10 cycles -> `rsp_*` stable, `req_ready`=0 throughout; on release, IDLE and the next grant follow in subsequent cycles.
- Reset mid-op: assert `rst_n`=0 during EXEC -> `rsp_valid`=0 immediately; after release, the first grant goes to requester 0.
- OPCHK: with macro defined, op=1111, op1=1, op2=1 -> `rsp_err`=1, `rsp_out`=0, `rsp_zero`=1; without macro, `rsp_err`=0.
